accumulate_arbiter: RTL and testbench



---
 rtl/accumulate_arbiter.sv | 138 +++++++++++++
 tb/tb_accumulate_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulate_arbiter.sv
// Round-robin arbiter that locks one requester onto a shared accumulator for
// 2**LOG_COUNT arguments, then presents the sum with the requester index.
module accumulate_arbiter #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned LOG_COUNT = 2,
    parameter int unsigned IDX_WIDTH = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DEPTH-1:0]             arg_stb,
    input  logic [DEPTH*WIDTH-1:0]       arg_dat,
    output logic [DEPTH-1:0]             arg_rdy,
    output logic                         res_stb,
    output logic [WIDTH+LOG_COUNT-1:0]   res_dat,
    output logic [IDX_WIDTH-1:0]         res_idx,
    input  logic                         res_rdy
);

    localparam int unsigned COUNT = 1 << LOG_COUNT;
    localparam int unsigned SUM_W = WIDTH + LOG_COUNT;
    localparam int unsigned CNT_W = (LOG_COUNT > 0) ? LOG_COUNT : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_OUTPUT = 2'd2;

    logic [1:0]           state,   state_nxt;
    logic [IDX_WIDTH-1:0] grant,   grant_nxt;
    logic [IDX_WIDTH-1:0] last,    last_nxt;
    logic [SUM_W-1:0]     acc,     acc_nxt;
    logic [CNT_W-1:0]     cnt,     cnt_nxt;
    logic                 res_stb_nxt;
    logic [SUM_W-1:0]     res_dat_nxt;
    logic [IDX_WIDTH-1:0] res_idx_nxt;

    logic [WIDTH-1:0]     arg_sel;
    logic                 xfer;
    logic                 pick_found;
    logic [IDX_WIDTH-1:0] pick_idx;

    // Accept strobe decoded purely from registered state and grant
    always_comb begin
        arg_rdy = '0;
        for (int unsigned n = 0; n < DEPTH; n++) begin
            arg_rdy[n] = (state == S_ACCUM) && (grant == IDX_WIDTH'(n));
        end
    end

    always_comb begin
        arg_sel = '0;
        for (int unsigned n = 0; n < DEPTH; n++) begin
            if (grant == IDX_WIDTH'(n)) begin
                arg_sel = arg_dat[n*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = |(arg_stb & arg_rdy);

    // Rotating scan starting just after the last served requester
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 1; k <= DEPTH; k++) begin : scan
            int unsigned c;
            c = (32'(last) + k) % DEPTH;
            if (!pick_found && arg_stb[c]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_WIDTH'(c);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        last_nxt    = last;
        acc_nxt     = acc;
        cnt_nxt     = cnt;
        res_stb_nxt = res_stb;
        res_dat_nxt = res_dat;
        res_idx_nxt = res_idx;
        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    grant_nxt = pick_idx;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (xfer) begin
                    acc_nxt = acc + SUM_W'(arg_sel);
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(COUNT - 1)) begin
                        res_dat_nxt = acc + SUM_W'(arg_sel);
                        res_idx_nxt = grant;
                        res_stb_nxt = 1'b1;
                        last_nxt    = grant;
                        state_nxt   = S_OUTPUT;
                    end
                end
            end
            S_OUTPUT: begin
                if (res_rdy) begin
                    res_stb_nxt = 1'b0;
                    state_nxt   = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            grant   <= '0;
            last    <= IDX_WIDTH'(DEPTH - 1);
            acc     <= '0;
            cnt     <= '0;
            res_stb <= 1'b0;
            res_dat <= '0;
            res_idx <= '0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            last    <= last_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            res_stb <= res_stb_nxt;
            res_dat <= res_dat_nxt;
            res_idx <= res_idx_nxt;
        end
    end

endmodule

// File: tb/tb_accumulate_arbiter.sv
// Bench for accumulate_arbiter: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_accumulate_arbiter;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned DEPTH     = 2;
    localparam int unsigned LOG_COUNT = 2;
    localparam int unsigned IDX_WIDTH = 1;
    localparam int unsigned COUNT     = 4;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [DEPTH-1:0]           arg_stb = '0;
    logic [DEPTH*WIDTH-1:0]     arg_dat = '0;
    logic [DEPTH-1:0]           arg_rdy;
    logic                       res_stb;
    logic [WIDTH+LOG_COUNT-1:0] res_dat;
    logic [IDX_WIDTH-1:0]       res_idx;
    logic                       res_rdy = 1'b0;

    accumulate_arbiter #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .LOG_COUNT(LOG_COUNT), .IDX_WIDTH(IDX_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(arg_rdy),
        .res_stb(res_stb), .res_dat(res_dat), .res_idx(res_idx), .res_rdy(res_rdy)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;

    // Reference model: who owns the accumulator (-1 = nobody), how much it has
    // sent, its running sum, and a pending result slot.
    int          m_owner;
    int          m_taken;
    int unsigned m_sum;
    bit          m_res_v;
    int unsigned m_res_d;
    int          m_res_i;
    int          m_last;
    bit          armed = 0;

    // Producers: per-requester data queues; observed results.
    int unsigned q0[$];
    int unsigned q1[$];
    int unsigned got_d[$];
    int          got_i[$];
    int          nx0, nx1, rdy0_cyc, stb_cyc;

    task automatic check_lit(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic model_update(input logic [1:0] stb, input int unsigned d0, input int unsigned d1,
                                input logic rr, input logic rs);
        int unsigned d;
        if (rs) begin
            m_owner = -1; m_taken = 0; m_sum = 0;
            m_res_v = 0; m_res_d = 0; m_res_i = 0; m_last = DEPTH - 1;
        end else if (m_res_v) begin
            if (rr) m_res_v = 0;
        end else if (m_owner >= 0) begin
            if (stb[m_owner]) begin
                d = (m_owner == 0) ? d0 : d1;
                m_sum += d;
                m_taken++;
                if (m_taken == COUNT) begin
                    m_res_v = 1; m_res_d = m_sum; m_res_i = m_owner;
                    m_last = m_owner; m_owner = -1;
                end
            end
        end else if (stb != 0) begin
            for (int k = 1; k <= DEPTH; k++) begin
                int c;
                c = (m_last + k) % DEPTH;
                if (m_owner < 0 && stb[c]) begin
                    m_owner = c; m_taken = 0; m_sum = 0;
                end
            end
        end
    endtask

    task automatic compare_cycle();
        logic [DEPTH-1:0] exp_rdy;
        exp_rdy = (m_owner >= 0) ? DEPTH'(1 << m_owner) : '0;
        tests++;
        if (arg_rdy !== exp_rdy || res_stb !== m_res_v ||
            res_dat !== 18'(m_res_d) || res_idx !== 1'(m_res_i)) begin
            errors++;
            $display("FAIL cycle @%0t: rdy=%b stb=%b dat=0x%0h idx=%0d, expected rdy=%b stb=%b dat=0x%0h idx=%0d",
                     $time, arg_rdy, res_stb, res_dat, res_idx, exp_rdy, m_res_v, m_res_d, m_res_i);
        end
        tests++;
        if ($countones(arg_rdy) > 1) begin
            errors++;
            $display("FAIL onehot: arg_rdy=%b, expected at most one bit", arg_rdy);
        end
    endtask

    task automatic step(input logic rr, input logic rs, input logic [1:0] gate);
        logic [1:0]  stb;
        int unsigned d0, d1;
        logic        x0, x1;
        @(negedge clk);
        if (armed) compare_cycle();
        stb[0] = (q0.size() > 0) && !gate[0];
        stb[1] = (q1.size() > 0) && !gate[1];
        d0 = (q0.size() > 0) ? q0[0] : 32'hDEAD;
        d1 = (q1.size() > 0) ? q1[0] : 32'hBEEF;
        rst = rs;
        arg_stb = stb;
        arg_dat = {16'(d1), 16'(d0)};
        res_rdy = rr;
        x0 = arg_rdy[0] & stb[0] & !rs;
        x1 = arg_rdy[1] & stb[1] & !rs;
        if (arg_rdy[0]) rdy0_cyc++;
        if (res_stb) stb_cyc++;
        if (res_stb && rr && !rs) begin
            got_d.push_back(32'(res_dat));
            got_i.push_back(int'(res_idx));
        end
        model_update(stb, d0, d1, rr, rs);
        @(posedge clk);
        if (x0) begin void'(q0.pop_front()); nx0++; end
        if (x1) begin void'(q1.pop_front()); nx1++; end
        if (rs) armed = 1;
    endtask

    task automatic do_reset();
        q0.delete(); q1.delete();
        step(1'b0, 1'b1, 2'b00);
        step(1'b0, 1'b1, 2'b00);
        got_d.delete(); got_i.delete();
        nx0 = 0; nx1 = 0; rdy0_cyc = 0; stb_cyc = 0;
    endtask

    initial begin
        int gap;
        int waited;
        int hold_x;

        // 1: single requester 1,2,3,4
        do_reset();
        #1 check_lit("reset_res_stb", res_stb, 0);
        check_lit("reset_res_dat", res_dat, 0);
        check_lit("reset_arg_rdy", arg_rdy, 0);
        q0 = '{1, 2, 3, 4};
        repeat (8) step(1'b1, 1'b0, 2'b00);
        check_lit("t1_rdy0_cycles", rdy0_cyc, 4);
        check_lit("t1_stb_cycles", stb_cyc, 1);
        check_lit("t1_nres", got_d.size(), 1);
        if (got_d.size() >= 1) begin
            check_lit("t1_dat", got_d[0], 10);
            check_lit("t1_idx", got_i[0], 0);
        end

        // 2: both requesting continuously, data 0 and 1
        do_reset();
        repeat (8) begin q0.push_back(0); q1.push_back(1); end
        repeat (26) step(1'b1, 1'b0, 2'b00);
        check_lit("t2_nres", got_d.size() >= 4, 1);
        if (got_d.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check_lit($sformatf("t2_idx%0d", i), got_i[i], i % 2);
                check_lit($sformatf("t2_dat%0d", i), got_d[i], (i % 2) * 4);
            end
        end

        // 3: full-scale arguments, no wrap
        do_reset();
        q1 = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        repeat (8) step(1'b1, 1'b0, 2'b00);
        check_lit("t3_nres", got_d.size(), 1);
        if (got_d.size() >= 1) begin
            check_lit("t3_dat", got_d[0], 32'h3FFFC);
            check_lit("t3_idx", got_i[0], 1);
        end

        // 4: consumer back-pressure holds the result
        do_reset();
        q0 = '{7, 7, 7, 7};
        waited = 0;
        while (!res_stb && waited < 20) begin step(1'b0, 1'b0, 2'b00); waited++; end
        check_lit("t4_res_seen", res_stb, 1);
        q1 = '{1, 1, 1, 1};
        hold_x = nx0 + nx1;
        repeat (5) step(1'b0, 1'b0, 2'b00);
        #1 check_lit("t4_hold_stb", res_stb, 1);
        check_lit("t4_hold_dat", res_dat, 28);
        check_lit("t4_hold_rdy", arg_rdy, 0);
        check_lit("t4_no_consume", nx0 + nx1, hold_x);
        step(1'b1, 1'b0, 2'b00);
        #1 check_lit("t4_cleared", res_stb, 0);

        // 5: owner stalls; other requester must wait
        do_reset();
        q0 = '{5, 6, 7, 8};
        q1 = '{9, 9, 9, 9};
        gap = 0;
        repeat (30) begin
            if (nx0 == 2 && gap < 3) begin
                step(1'b1, 1'b0, 2'b01);
                gap++;
            end else begin
                step(1'b1, 1'b0, 2'b00);
            end
        end
        check_lit("t5_nres", got_d.size(), 2);
        if (got_d.size() >= 2) begin
            check_lit("t5_dat0", got_d[0], 26);
            check_lit("t5_idx0", got_i[0], 0);
            check_lit("t5_dat1", got_d[1], 36);
            check_lit("t5_idx1", got_i[1], 1);
        end

        // 6: reset mid-accumulation discards the partial sum
        do_reset();
        q1 = '{1, 2, 3, 4};
        waited = 0;
        while (nx1 < 2 && waited < 20) begin step(1'b1, 1'b0, 2'b00); waited++; end
        check_lit("t6_two_args", nx1, 2);
        q0.delete(); q1.delete();
        step(1'b1, 1'b1, 2'b00);
        #1 check_lit("t6_stb_after_rst", res_stb, 0);
        check_lit("t6_rdy_after_rst", arg_rdy, 0);
        got_d.delete(); got_i.delete();
        q0 = '{3, 3, 3, 3};
        q1 = '{3, 3, 3, 3};
        repeat (14) step(1'b1, 1'b0, 2'b00);
        check_lit("t6_nres", got_d.size(), 2);
        if (got_d.size() >= 1) begin
            check_lit("t6_dat", got_d[0], 12);
            check_lit("t6_idx", got_i[0], 0);
        end

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] g;
            if ($urandom_range(0, 3) == 0 && q0.size() < 8) q0.push_back($urandom_range(0, 16'hFFFF));
            if ($urandom_range(0, 3) == 0 && q1.size() < 8) q1.push_back($urandom_range(0, 16'hFFFF));
            g = 2'($urandom_range(0, 3)) & {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
            step($urandom_range(0, 9) < 7, $urandom_range(0, 299) == 0, g);
        end
        step(1'b1, 1'b0, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
